// File: rtl/shared_nibble_adder_ctrl_pkg.sv
// Shared types and constants for the time-multiplexed nibble adder controller.
package shared_nibble_adder_ctrl_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Nibble counter width; never narrower than one bit so NIBBLES=1 still builds.
    function automatic int cnt_width(input int nibbles);
        return (nibbles <= 2) ? 1 : $clog2(nibbles);
    endfunction

endpackage

// File: rtl/shared_nibble_adder_ctrl_if.sv
// Request/response bundle between two requesters, the controller and the result consumer.
interface shared_nibble_adder_ctrl_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         req0_valid;
    logic         req0_ready;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic         req0_cin;

    logic         req1_valid;
    logic         req1_ready;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic         req1_cin;

    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_sum;
    logic         rsp_cout;
    logic         rsp_id;

    modport master (
        output req0_valid, req0_a, req0_b, req0_cin,
        output req1_valid, req1_a, req1_b, req1_cin,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_sum, rsp_cout, rsp_id
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_cin,
        input  req1_valid, req1_a, req1_b, req1_cin,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_sum, rsp_cout, rsp_id
    );

endinterface

// File: rtl/shared_nibble_adder_ctrl_nibble_adder_cin.sv
// The single shared 4-bit adder slice with carry-in.
module nibble_adder_cin
    import shared_nibble_adder_ctrl_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};

endmodule

// File: rtl/shared_nibble_adder_ctrl.sv
// Round-robin controller that ripples a wide add through one nibble slice, LSB first.
// state | meaning
// IDLE  | arbitrate; on accept latch operands, id and cin
// ADD   | one nibble per cycle through the shared slice, carry kept in carry_q
// DONE  | result held on rsp_* until rsp_ready
module shared_nibble_adder_ctrl
    import shared_nibble_adder_ctrl_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    shared_nibble_adder_ctrl_if.slave bus
);

    localparam int             W    = NIBBLE_W * NIBBLES;
    localparam int             CW   = cnt_width(NIBBLES);
    localparam logic [CW-1:0]  LAST = CW'(NIBBLES - 1);

    state_e          state_q, state_d;
    logic            last_grant_q, last_grant_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic            id_q, id_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [W-1:0]    rsp_sum_q, rsp_sum_d;
    logic            rsp_cout_q, rsp_cout_d;

    logic                grant;
    logic                accept;
    logic [NIBBLE_W-1:0] slice_a, slice_b, slice_sum;
    logic                slice_cout;

    always_comb begin
        if (bus.req0_valid && bus.req1_valid) grant = ~last_grant_q;
        else                                  grant = bus.req1_valid;
    end

    assign bus.req0_ready = rst_n && (state_q == IDLE) && bus.req0_valid && !grant;
    assign bus.req1_ready = rst_n && (state_q == IDLE) && bus.req1_valid &&  grant;
    assign accept         = bus.req0_ready || bus.req1_ready;

    always_comb begin
        slice_a = '0;
        slice_b = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (cnt_q == CW'(i)) begin
                slice_a = a_q[i*NIBBLE_W +: NIBBLE_W];
                slice_b = b_q[i*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    nibble_adder_cin u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        carry_d      = carry_q;
        a_d          = a_q;
        b_d          = b_q;
        id_d         = id_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_sum_d    = rsp_sum_q;
        rsp_cout_d   = rsp_cout_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    id_d         = grant;
                    last_grant_d = grant;
                    a_d          = grant ? bus.req1_a   : bus.req0_a;
                    b_d          = grant ? bus.req1_b   : bus.req0_b;
                    carry_d      = grant ? bus.req1_cin : bus.req0_cin;
                    cnt_d        = '0;
                    state_d      = ADD;
                end
            end
            ADD: begin
                for (int i = 0; i < NIBBLES; i++) begin
                    if (cnt_q == CW'(i)) rsp_sum_d[i*NIBBLE_W +: NIBBLE_W] = slice_sum;
                end
                carry_d = slice_cout;
                if (cnt_q == LAST) begin
                    rsp_cout_d  = slice_cout;
                    rsp_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset leaves last_grant at 1 so requester 0 wins the first contested round.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            carry_q      <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_sum_q    <= '0;
            rsp_cout_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            carry_q      <= carry_d;
            a_q          <= a_d;
            b_q          <= b_d;
            id_q         <= id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_sum_q    <= rsp_sum_d;
            rsp_cout_q   <= rsp_cout_d;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_sum   = rsp_sum_q;
    assign bus.rsp_cout  = rsp_cout_q;
    assign bus.rsp_id    = id_q;

endmodule
